// File: rtl/vm_pkg.sv
// vm_pkg: state encodings and default timing shared by the vending board I/O blocks
package vm_pkg;
  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_ON   = 2'd1,
    PS_GAP  = 2'd2
  } ps_state_t;
  // 30 ms at 50 MHz
  localparam int DEF_CYCLES = 1500000;
endpackage

// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: event request in, stretched pulse and status out
interface pulse_stretch_if #(parameter int PEND_W = 3);
  logic              trig;
  logic              out;
  logic              busy;
  logic              dropped;
  logic [PEND_W-1:0] pending;
  modport master (output trig, input out, busy, dropped, pending);
  modport slave  (input trig, output out, busy, dropped, pending);
endinterface

// File: rtl/pulse_stretch_cycle_timer.sv
// cycle_timer: up-counter with clear/enable that flags when it reaches a terminal value
module cycle_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  assign done = cnt == term;
  // count while enabled, restart from zero on clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches single-cycle events into ON/GAP pulses; PULSE_STRETCH_QUEUE_EN queues events arriving while busy
module pulse_stretch
  import vm_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_CYCLES,
  parameter int OFF_CYCLES = DEF_CYCLES,
  parameter int CNT_W      = 25,
  parameter int PEND_W     = 3
) (
  input logic             clk,
  input logic             reset_n,
  pulse_stretch_if.slave  bus
);
  if (ON_CYCLES < 1 || OFF_CYCLES < 1 ||
      ((ON_CYCLES - 1) >> CNT_W) != 0 || ((OFF_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cfg
    $error("pulse_stretch: CNT_W too small for ON_CYCLES/OFF_CYCLES, or a length below 1");
  end
  ps_state_t        state, state_n;
  logic             done, last_gap, drop, has_pend;
  logic [CNT_W-1:0] term;
`ifdef PULSE_STRETCH_QUEUE_EN
  logic [PEND_W-1:0] pend, pend_n;
  // queue bookkeeping: the last GAP cycle dequeues unless a new event replaces the dequeued one
  always_comb begin
    pend_n = pend;
    drop   = 1'b0;
    if (last_gap) pend_n = pend - PEND_W'(pend != '0 && !bus.trig);
    else if (state != PS_IDLE && bus.trig) begin
      drop   = pend == '1;
      pend_n = drop ? pend : pend + 1'b1;
    end
  end
  // pending count register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pend <= '0;
    else pend <= pend_n;
  assign has_pend    = pend != '0;
  assign bus.pending = pend;
`else
  assign drop        = bus.trig && state != PS_IDLE && !last_gap;
  assign has_pend    = 1'b0;
  assign bus.pending = '0;
`endif
  // next state; a trig on the final GAP cycle chains straight into the next pulse
  always_comb begin
    term     = state == PS_ON ? CNT_W'(ON_CYCLES - 1) : CNT_W'(OFF_CYCLES - 1);
    last_gap = state == PS_GAP && done;
    state_n  = state == PS_IDLE ? (bus.trig ? PS_ON : PS_IDLE) :
               state == PS_ON   ? (done ? PS_GAP : PS_ON) :
               last_gap         ? ((has_pend || bus.trig) ? PS_ON : PS_IDLE) : PS_GAP;
  end
  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (state_n != state),
    .en     (state != PS_IDLE),
    .term   (term),
    .done   (done)
  );
  // state and registered outputs, derived from the state being entered
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= PS_IDLE;
      bus.out     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.dropped <= 1'b0;
    end else begin
      state       <= state_n;
      bus.out     <= state_n == PS_ON;
      bus.busy    <= state_n != PS_IDLE;
      bus.dropped <= drop;
    end
endmodule
